// File: rtl/arb8_decode_ctrl.sv
// Round-robin owner select for a decoder-shared resource; grant held until done, request drop or hold limit.
// Latency: one edge from request to registered sel/en. No backpressure: a grant is revoked after MAX_HOLD cycles.
module arb8_decode_ctrl #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic       en,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             timeout_q, timeout_d;

    logic             win_vld;
    logic [2:0]       win_idx;
    logic             hold_last;

    // Scan from the far end toward ptr so the lowest offset from ptr is the last one written.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr_q + 3'(i)]) begin
                win_vld = 1'b1;
                win_idx = ptr_q + 3'(i);
            end
        end
    end

    assign hold_last = (hcnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        hcnt_d    = hcnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    sel_d   = win_idx;
                    hcnt_d  = '0;
                end
            end
            GRANT: begin
                // done outranks the hold limit, so a coincident done never flags a timeout.
                if (done || !req[sel_q] || hold_last) begin
                    state_d   = IDLE;
                    ptr_d     = sel_q + 3'd1;
                    hcnt_d    = '0;
                    timeout_d = !done && req[sel_q];
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            sel_q     <= 3'd0;
            hcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            hcnt_q    <= hcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign en      = (state_q == GRANT);
    assign busy    = en;
    assign grant   = en ? (8'd1 << sel_q) : 8'd0;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arb8_decode_ctrl.sv
// Bench for arb8_decode_ctrl: directed scenarios plus random traffic against a cycle-level owner/queue model.
module tb_arb8_decode_ctrl;
    localparam int MH = 16;
    localparam int CW = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req   = 8'h00;
    logic       done  = 1'b0;
    logic [2:0] sel;
    logic       en;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Model: who owns the resource, how many cycles it has been visible, and where the next search starts.
    bit m_en;
    int m_sel;
    int m_ptr;
    int m_held;
    bit m_to;

    arb8_decode_ctrl #(.MAX_HOLD(MH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .sel(sel), .en(en), .grant(grant), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_to = 0;
    endtask

    task automatic model_edge();
        bit found;
        m_to = 0;
        if (m_en) begin
            if (done || !req[m_sel] || m_held == MH) begin
                m_to  = !done && req[m_sel];
                m_en  = 0;
                m_ptr = (m_sel + 1) % 8;
            end else begin
                m_held++;
            end
        end else if (req != 8'h00) begin
            found = 0;
            for (int i = 0; i < 8; i++) begin
                if (!found && req[(m_ptr + i) % 8]) begin
                    found  = 1;
                    m_sel  = (m_ptr + i) % 8;
                end
            end
            m_en   = 1;
            m_held = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".en"}, 32'(en), 32'(m_en));
        chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
        chk({tag, ".grant"}, 32'(grant), m_en ? (32'd1 << m_sel) : 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'(m_en));
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
    task automatic cyc(input logic [7:0] r, input logic d, input string tag);
        req  = r;
        done = d;
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        int n;
        logic [2:0] sel_keep;
        logic [7:0] r;

        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all("reset");
        reset = 1'b0;

        // Round robin with full request and a done pulse on each grant.
        for (int i = 0; i < 16; i++) begin
            cyc(8'hFF, 1'b0, "rr_grant");
            chk("rr_sel", 32'(sel), 32'(i % 8));
            chk("rr_en", 32'(en), 32'd1);
            cyc(8'hFF, 1'b1, "rr_rel");
            chk("rr_dead", 32'(en), 32'd0);
        end

        // Pointer skip and 7->0 wrap.
        cyc(8'h84, 1'b0, "wrap");  chk("wrap_sel0", 32'(sel), 32'd2);
        cyc(8'h84, 1'b1, "wrap");
        cyc(8'h84, 1'b0, "wrap");  chk("wrap_sel1", 32'(sel), 32'd7);
        cyc(8'h84, 1'b1, "wrap");
        cyc(8'h84, 1'b0, "wrap");  chk("wrap_sel2", 32'(sel), 32'd2);
        cyc(8'h84, 1'b1, "wrap");

        // Hold limit: en high for exactly MH cycles, then a one-cycle timeout pulse.
        cyc(8'h08, 1'b0, "to_grant");
        n = 0;
        while (en && n < 40) begin
            n++;
            cyc(8'h08, 1'b0, "to_hold");
        end
        chk("to_len", 32'(n), 32'(MH));
        chk("to_pulse", 32'(timeout), 32'd1);
        cyc(8'h08, 1'b0, "to_regrant");
        chk("to_regrant_sel", 32'(sel), 32'd3);
        chk("to_regrant_en", 32'(en), 32'd1);
        chk("to_pulse_end", 32'(timeout), 32'd0);
        cyc(8'h08, 1'b1, "to_rel");

        // Requester drop is a release without timeout.
        cyc(8'h20, 1'b0, "drop_grant");
        chk("drop_sel", 32'(sel), 32'd5);
        cyc(8'h00, 1'b0, "drop");
        chk("drop_en", 32'(en), 32'd0);
        chk("drop_to", 32'(timeout), 32'd0);

        // done coinciding with the hold limit wins.
        cyc(8'h20, 1'b0, "dl_grant");
        for (int i = 0; i < MH - 1; i++) cyc(8'h20, 1'b0, "dl_hold");
        chk("dl_still_en", 32'(en), 32'd1);
        cyc(8'h20, 1'b1, "dl_rel");
        chk("dl_en", 32'(en), 32'd0);
        chk("dl_to", 32'(timeout), 32'd0);

        // Idle with done toggling.
        sel_keep = sel;
        for (int i = 0; i < 50; i++) cyc(8'h00, 1'(i & 1), "idle");
        chk("idle_sel", 32'(sel), 32'(sel_keep));

        // Asynchronous reset in the middle of a grant.
        cyc(8'hFF, 1'b0, "rst_grant");
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_grant_vec", 32'(grant), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        cyc(8'hFF, 1'b0, "rst_hold");
        reset = 1'b0;
        cyc(8'hFF, 1'b0, "rst_first");
        chk("rst_first_sel", 32'(sel), 32'd0);
        chk("rst_first_grant", 32'(grant), 32'h01);
        cyc(8'hFF, 1'b1, "rst_rel");

        // Random traffic with long request holds so timeouts occur.
        r = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 23) == 0) begin
                case ($urandom_range(0, 3))
                    0: r = 8'h00;
                    1: r = 8'd1 << $urandom_range(0, 7);
                    2: r = 8'($urandom);
                    default: r = 8'hFF;
                endcase
            end
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                compare_all("rnd_rst");
                cyc(r, 1'b0, "rnd_rst_hold");
                reset = 1'b0;
            end
            cyc(r, $urandom_range(0, 9) == 0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb8_decode_ctrl.md
# arb8_decode_ctrl

Round-robin arbiter and scheduler that shares a single 3-to-8 decoder-driven resource among eight requesters. It picks one requester and holds the grant until release or timeout. It drives the decoder's 3-bit select and enable, and exposes the resulting one-hot grant vector. It sits between the requesting agents and the decoder/resource select path.

## Interface
- MAX_HOLD, default 16: maximum cycles a single grant may be held; legal range 1..2^CNT_W.
- CNT_W, default 4: width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.
- clk, input, 1: sole clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, 8: request lines; bit i = requester i.
- done, input, 1: current owner releases the grant; sampled only in GRANT.
- sel, output, 3: registered index of the granted requester (decoder select input).
- en, output, 1: registered grant valid (decoder enable).
- grant, output, 8: one-hot decode of sel gated by en; all zero when en=0.
- busy, output, 1: high while in GRANT (equals en).
- timeout, output, 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- States: IDLE, GRANT. Internal: 3-bit round-robin pointer ptr, CNT_W-bit hold counter hcnt.
- Reset (asynchronous, immediate): state=IDLE, ptr=0, hcnt=0, sel=0, en=0, grant=0, busy=0, timeout=0.
- IDLE, req==0: stay; outputs unchanged (en=0, sel holds last value).
- IDLE, req!=0: winner = first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8). At the edge: sel=winner, en=1, hcnt=0, state=GRANT.
- GRANT release conditions, evaluated each edge in priority order:
  1. done=1: normal release.
  2. req[sel]=0: requester dropped; treated as release.
  3. hcnt==MAX_HOLD-1: forced release; timeout=1 for exactly the following cycle.
- On release: en=0, state=IDLE, ptr=sel+1 (mod 8, wraps 7→0), hcnt=0. sel keeps its value.
- On no release: hcnt increments by 1.
- Fairness: a requester that just released has lowest priority on the next arbitration. The requester that was forced off by timeout is also rotated to lowest priority.
- grant is combinational from registered sel/en: grant = en ? (8'b1 << sel) : 8'b0. It is never more than one-hot.
- Requests arriving or dropping while another requester holds the grant do not affect the current grant.
- timeout is high only in the cycle immediately after a forced release; it is 0 otherwise.
- If done=1 and hcnt==MAX_HOLD-1 at the same edge, done wins and timeout stays 0.
- done in IDLE is ignored.
- MAX_HOLD=1: every grant lasts one cycle. Release is normal if done or req[sel] drops that edge; otherwise it is a timeout.

## Timing
- Grant latency: req sampled high at edge k in IDLE → en=1 and sel valid after edge k (1 cycle).
- Hold: en stays high for the cycles spanning edges k..m, where m is the first edge satisfying a release condition. en=0 after edge m.
- Dead cycle: after any release there is at least one cycle with en=0 before the next grant. The earliest next grant is after edge m+1. There is no back-to-back grant overlap.
- Maximum en-high duration: MAX_HOLD cycles.
- Worst-case wait for a continuously requesting agent: 7 × (MAX_HOLD+1) cycles from its request to its grant.
- reset asserted mid-GRANT clears en/grant immediately, without waiting for a clock edge. After reset deasserts, the first arbitration starts from ptr=0.

## Test plan
- Reset: assert reset mid-grant with req=8'hFF → en=0, grant=0, timeout=0 immediately. After release, the first grant is sel=0, grant=8'h01 one edge later.
- Round-robin: hold req=8'hFF and pulse done on every grant → grants sel=0,1,2,...,7,0. Each grant is separated by one en=0 cycle.
- Pointer skip and wrap: req=8'b1000_0100 with done pulses → sel=2, then 7, then 2. Confirm the wrap 7→0 search finds bit 2.
- Timeout: MAX_HOLD=16, req=8'h08 held, done=0 → en high exactly 16 cycles, then en=0 with timeout=1 for one cycle. Regrant to sel=3 follows one cycle later.
- Drop and priority: grant sel=5, then drop req[5] → en=0 next edge with timeout=0. Assert done and the hold limit on the same edge → timeout=0.
- Idle stability: req=0 for 50 cycles with done toggling → en=0, grant=0, timeout=0 throughout, and sel unchanged.
